bt656_embsync_decoder: RTL

- Parametrised successor to the fixed-code parallel-to-CSI2 front-end sync decoder.
- Decodes ITU-R BT.656-style embedded timing reference codes (preamble FF/00/00 then XY) from a parallel camera bus.
- Generates FV, LV and FIELD aligned to a registered copy of the pixel data, and feeds the CSI-2 packetiser.
- Adds generic XY decoding with protection-bit checking, configurable data width and geometry, interlaced mode, line clipping and error flags.

---
 rtl/bt656_embsync_decoder.sv | 82 ++++++++
 1 files changed

// File: rtl/bt656_embsync_decoder.sv
// bt656_embsync_decoder: decodes BT.656 embedded FF/00/00/XY timing codes into FV/LV/FIELD aligned with a 2-cycle delayed data bus.
module bt656_embsync_decoder #(
  parameter int DATA_W = 8,
  parameter int ACTIVE_PIX = 1280,
  parameter int MAX_LINES = 480,
  parameter int INTERLACED = 0,
  parameter int CNT_W = 12
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              FV,
  output logic              LV,
  output logic              FIELD,
  output logic [CNT_W-1:0]  line_count,
  output logic              frame_start,
  output logic              sync_err,
  output logic              line_err
);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(ACTIVE_PIX - 1);
  typedef enum logic [1:0] {IDLE, P1, P2, XY} state_t;
  state_t state, state_n;
  logic [7:0] c;
  logic [DATA_W-1:0] d1;
  logic [CNT_W-1:0] pix, lc_eff;
  logic [1:0] start_d;
  logic is_xy, code_ok, valid, bad, sav0, fv_drop, lv_drop, pass;
  assign c = data_in[DATA_W-1 -: 8];
  always_ff @(posedge clock_in)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (c == 8'hFF) ? P1 :
              (c == 8'h00 && state == P1) ? P2 :
              (c == 8'h00 && state == P2) ? XY : IDLE;
  // An FF in the XY slot restarts the preamble and is not treated as a code.
  always_comb begin
    is_xy = state == XY && c != 8'hFF;
    code_ok = c[7] && c[3:0] == {c[5] ^ c[4], c[6] ^ c[4], c[6] ^ c[5], c[6] ^ c[5] ^ c[4]};
    valid = is_xy && code_ok;
    bad = is_xy && !code_ok;
    sav0 = valid && !c[5] && !c[4];
    fv_drop = valid && c[5];
    lv_drop = valid && (c[5] || c[4]);
    lc_eff = FV ? line_count : '0;
    pass = sav0 && int'(lc_eff) < MAX_LINES;
  end
  // LV start is delayed two edges so pixel 0 reaches data_out together with LV.
  always_ff @(posedge clock_in)
    if (reset) begin
      d1 <= '0;
      data_out <= '0;
      FV <= 1'b0;
      LV <= 1'b0;
      FIELD <= 1'b0;
      line_count <= '0;
      frame_start <= 1'b0;
      sync_err <= 1'b0;
      line_err <= 1'b0;
      pix <= '0;
      start_d <= '0;
    end else begin
      d1 <= data_in;
      data_out <= d1;
      sync_err <= bad;
      line_err <= valid && LV;
      frame_start <= sav0 && !FV;
      start_d <= {start_d[0], pass};
      if (fv_drop) FV <= 1'b0;
      else if (sav0) FV <= 1'b1;
      if (INTERLACED != 0 && sav0 && !FV) FIELD <= c[6];
      if (sav0) line_count <= &lc_eff ? lc_eff : lc_eff + 1'b1;
      if (start_d[1]) begin
        LV <= 1'b1;
        pix <= '0;
      end else if (lv_drop || (LV && pix == LAST_PIX)) begin
        LV <= 1'b0;
        pix <= '0;
      end else if (LV) pix <= pix + 1'b1;
    end
endmodule
